// File: rtl/rf_write_controller_pkg.sv
// Shared CPU definitions for the register-file writeback path.
package rf_write_controller_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_write_controller_wb_fifo.sv
// In-order circular buffer of pending register writes, with a per-entry
// dest/valid view used by the hazard compare in the top level.
module wb_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_dest,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] pop_dest,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] ent_dest  [DEPTH],
  output logic              ent_valid [DEPTH]
);
  import rf_write_controller_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [ADDR_W-1:0] dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_dest = dest_q[head_q];
  assign pop_data = data_q[head_q];

  // Next-state for pointers, count and storage; pointers wrap naturally at PTR_W bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (push) begin
      dest_d[tail_q] = push_dest;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Entry i is live when its distance from head is below count.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset       = PTR_W'(i) - head_q;
      ent_dest[i]  = dest_q[i];
      ent_valid[i] = ({1'b0, offset} < count_q);
    end
  end

  // Pointer/count registers; storage is not cleared since validity derives from count.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/rf_write_controller.sv
// Writeback controller: queues results, drives the register-file write port
// at one write per cycle, and flags source operands with pending writes.
module rf_write_controller #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_enable,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              empty
);
  import rf_write_controller_pkg::*;

  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic [ADDR_W-1:0] pop_dest;
  logic [DATA_W-1:0] pop_data;
  logic [ADDR_W-1:0] ent_dest  [DEPTH];
  logic              ent_valid [DEPTH];

  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && wb_enable;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wb_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_dest (in_dest),
    .push_data (in_data),
    .pop       (pop),
    .pop_dest  (pop_dest),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_dest  (ent_dest),
    .ent_valid (ent_valid)
  );

  // Output stage: load head entry on a pop, otherwise hold address/data and drop the strobe.
  always_comb begin
    rf_write_d      = pop;
    rf_write_addr_d = rf_write_addr_q;
    rf_write_data_d = rf_write_data_q;
    if (pop) begin
      rf_write_addr_d = pop_dest;
      rf_write_data_d = pop_data;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_q      <= 1'b0;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
    end else begin
      rf_write_q      <= rf_write_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
    end
  end

  // Hazard flags: output stage still counts since the RF commits at the end of the cycle.
  always_comb begin
    busy1 = rf_write_q && (rf_write_addr_q == rs1_addr);
    busy2 = rf_write_q && (rf_write_addr_q == rs2_addr);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_dest[i] == rs1_addr)) busy1 = 1'b1;
      if (ent_valid[i] && (ent_dest[i] == rs2_addr)) busy2 = 1'b1;
    end
  end

  assign rf_write      = rf_write_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;
  assign empty         = fifo_empty && !rf_write_q;

endmodule

// File: tb/tb_rf_write_controller.sv
// Scoreboard bench for rf_write_controller.
module tb_rf_write_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_dest;
  logic [15:0] in_data;
  logic        wb_enable;
  logic [1:0]  rs1_addr;
  logic [1:0]  rs2_addr;
  logic        busy1, busy2;
  logic        rf_write;
  logic [1:0]  rf_write_addr;
  logic [15:0] rf_write_data;
  logic        empty;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [17:0] sb [$];
  logic [15:0] rf_model [4];

  always #5 clk = ~clk;

  rf_write_controller #(
    .DEPTH  (4),
    .DATA_W (16),
    .ADDR_W (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dest       (in_dest),
    .in_data       (in_data),
    .wb_enable     (wb_enable),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .busy1         (busy1),
    .busy2         (busy2),
    .rf_write      (rf_write),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .empty         (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest accepted push.
  always @(negedge clk) begin
    if (rf_write === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 32'(rf_write_addr), 32'hFFFF_FFFF);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        check("sb_addr", 32'(rf_write_addr), 32'(e[17:16]));
        check("sb_data", 32'(rf_write_data), 32'(e[15:0]));
        rf_model[rf_write_addr] = rf_write_data;
      end
    end
  end

  // Drive one cycle; record accepted pushes just before the edge, return #1 after it.
  task automatic step(input logic v, input logic [1:0] d, input logic [15:0] x, input logic en);
    in_valid  = v;
    in_dest   = d;
    in_data   = x;
    wb_enable = en;
    @(negedge clk);
    if (!reset && in_valid && in_ready) sb.push_back({in_dest, in_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    while ((sb.size() != 0 || !empty) && n < 30) begin
      step(1'b0, 2'd0, 16'h0, 1'b1);
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0;
    wb_enable = 1'b1; rs1_addr = 2'd2; rs2_addr = 2'd3;
    for (int i = 0; i < 4; i++) rf_model[i] = '0;
    step(1'b0, 2'd0, 16'h0, 1'b1);
    step(1'b0, 2'd0, 16'h0, 1'b1);
    reset = 1'b0;

    // Reset state
    check("rst_rf_write", 32'(rf_write), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_addr", 32'(rf_write_addr), 32'd0);
    check("rst_data", 32'(rf_write_data), 32'd0);

    // Single push latency
    step(1'b1, 2'd2, 16'h1234, 1'b1);
    check("lat_c1_rf_write", 32'(rf_write), 32'd0);
    check("lat_c1_empty", 32'(empty), 32'd0);
    check("lat_c1_busy1", 32'(busy1), 32'd1);
    check("lat_c1_busy2", 32'(busy2), 32'd0);
    step(1'b0, 2'd0, 16'h0, 1'b1);
    check("lat_c2_rf_write", 32'(rf_write), 32'd1);
    check("lat_c2_addr", 32'(rf_write_addr), 32'd2);
    check("lat_c2_data", 32'(rf_write_data), 32'h1234);
    check("lat_c2_busy1", 32'(busy1), 32'd1);
    step(1'b0, 2'd0, 16'h0, 1'b1);
    check("lat_c3_rf_write", 32'(rf_write), 32'd0);
    check("lat_c3_empty", 32'(empty), 32'd1);
    check("lat_c3_hold_data", 32'(rf_write_data), 32'h1234);

    // Fill with writeback held, then release
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'(i), 16'(i + 1), 1'b0);
      check("fill_no_write", 32'(rf_write), 32'd0);
    end
    check("fill_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 2'd3, 16'hDEAD, 1'b0);
    check("frozen_in_ready", 32'(in_ready), 32'd0);
    check("frozen_rf_write", 32'(rf_write), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, 16'h0, 1'b1);
      check("rel_rf_write", 32'(rf_write), 32'd1);
      check("rel_addr", 32'(rf_write_addr), 32'(i));
      check("rel_in_ready", 32'(in_ready), 32'd1);
    end
    step(1'b0, 2'd0, 16'h0, 1'b1);
    check("rel_done", 32'(rf_write), 32'd0);

    // Same-register writes: busy and last-write-wins
    rs1_addr = 2'd1; rs2_addr = 2'd0;
    step(1'b1, 2'd1, 16'hAAAA, 1'b1);
    check("waw_busy1_c1", 32'(busy1), 32'd1);
    check("waw_busy2_c1", 32'(busy2), 32'd0);
    step(1'b1, 2'd1, 16'hBBBB, 1'b1);
    check("waw_busy1_c2", 32'(busy1), 32'd1);
    step(1'b0, 2'd0, 16'h0, 1'b1);
    check("waw_busy1_c3", 32'(busy1), 32'd1);
    check("waw_data_c3", 32'(rf_write_data), 32'hBBBB);
    step(1'b0, 2'd0, 16'h0, 1'b1);
    check("waw_busy1_c4", 32'(busy1), 32'd0);
    check("waw_final", 32'(rf_model[1]), 32'hBBBB);

    // Full queue with in_valid held high while draining
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 16'h100 + 16'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 1'b1);
      check("stream_rf_write", 32'(rf_write), 32'd1);
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    drain("stream");

    // Wrap-around
    for (int i = 0; i < 10; i++) step(1'b1, 2'(i % 4), 16'hC000 + 16'(i), 1'b1);
    drain("wrap");

    // Reset with entries pending
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 16'hE000 + 16'(i), 1'b0);
    check("prerst_busy1", 32'(busy1), 32'd1);
    reset = 1'b1;
    sb.delete();
    step(1'b0, 2'd0, 16'h0, 1'b1);
    reset = 1'b0;
    check("mrst_rf_write", 32'(rf_write), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_busy1", 32'(busy1), 32'd0);
    check("mrst_busy2", 32'(busy2), 32'd0);
    check("mrst_addr", 32'(rf_write_addr), 32'd0);
    check("mrst_data", 32'(rf_write_data), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 16'h0, 1'b1);
      check("postrst_no_write", 32'(rf_write), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rf_write_controller.md
# rf_write_controller

Writeback-side companion to the four-entry 16-bit register file in the cached multi-cycle TSC CPU. It buffers completed results from the ALU and cache paths in an in-order queue and drives the register file's write port at no more than one write per cycle. It also supplies per-operand busy flags so decode can stall on registers that still have writes pending. It is the writer for the register file's read/write/forwarding interface.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, at least 2
- DATA_W, 16, result width
- ADDR_W, 2, register index width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  the producer presents a result
- in_ready  out  1  the queue can accept an entry; equals !full
- in_dest  in  ADDR_W  destination register of the result
- in_data  in  DATA_W  result value
- wb_enable  in  1  permits a drain this cycle; 0 holds the queue, e.g. during a cache-port conflict
- rs1_addr, rs2_addr  in  ADDR_W  decode-stage source registers
- busy1, busy2  out  1  the matching source has a pending write
- rf_write  out  1  write strobe to the register file
- rf_write_addr  out  ADDR_W  write register index
- rf_write_data  out  DATA_W  write data
- empty  out  1  the queue and the output stage hold no pending write

## Operation
- Circular buffer with head and tail pointers of log2(DEPTH) bits, plus a count from 0 to DEPTH.
- Push: when in_valid and in_ready are both 1, write {in_dest, in_data} at tail; tail wraps modulo DEPTH.
- Pop: when count > 0 and wb_enable = 1, read the head entry into the output stage, set rf_write = 1, and advance head with wrap.
- Otherwise rf_write = 0. rf_write_addr and rf_write_data hold their last values.
- Push and pop in the same cycle leave count unchanged. A push while full is impossible because in_ready = 0. A pop while empty does not occur.
- There is no bypass from the input to the output stage. Every entry passes through the queue.
- busy1 = (rf_write && rf_write_addr == rs1_addr) OR (some valid queue entry has dest == rs1_addr). busy2 uses rs2_addr the same way. The output stage is included because the register file commits on the edge that ends the cycle.
- Entries drain in strict arrival order. Repeated writes to the same register therefore commit in order, and the last write wins.
- empty = (count == 0) && !rf_write.

## Timing
- Reset values: head, tail and count = 0; rf_write = 0; rf_write_addr = 0; rf_write_data = 0; busy1 = busy2 = 0; empty = 1; in_ready = 1.
- If reset is asserted mid-operation, all pending entries are discarded and are never written. Queue contents need no clearing because the valid range is derived from count.
- Latency: an entry pushed at edge N is popped at edge N+1 when it is at the head and wb_enable = 1. rf_write is high during cycle N+1 to N+2. The register file commits at edge N+2.
- Throughput is one write per cycle while wb_enable = 1.
- in_ready, busy1, busy2 and empty are combinational from registered state and the source address inputs. They never depend on in_valid.
- While wb_enable = 0 the queue is frozen. When wb_enable returns to 1, draining resumes in the next cycle with no entry lost.

## Structure
- The shared CPU package holds DATA_W, ADDR_W and NUM_REGS = 4, plus the typedef wb_entry_t = {dest, data}.
- One sub-module, wb_fifo: a synchronous circular buffer with count, full and empty, and a parallel per-entry dest/valid view for the hazard compare.
- The top level contains the output stage and the busy logic.

## Test plan
- After reset: rf_write = 0, empty = 1, in_ready = 1, busy1 = busy2 = 0. Push r2 = 16'h1234 at edge 1 -> rf_write = 1 with addr = 2 and data = 16'h1234 during cycle 2; empty = 1 from cycle 3.
- With wb_enable = 0, push four entries r0..r3 (0x0001..0x0004) -> in_ready = 0 after the fourth push. Raise wb_enable -> four consecutive writes in order, and in_ready = 1 after the first pop.
- Push r1 = 0xAAAA, then r1 = 0xBBBB -> busy1 = 1 with rs1_addr = 1 until the cycle after the second write strobe. The final register value is 0xBBBB.
- Full queue plus in_valid held high with wb_enable = 1 -> a pop and a push occur in the same cycle, count stays at DEPTH - 1 or below, and no entry is duplicated or dropped across 20 random cycles.
- Wrap-around: 10 sequential pushes and pops -> tail and head wrap, and the data order matches.
- Assert reset with three entries pending -> no further rf_write pulses; all outputs return to their reset values one cycle later.
